// File: rtl/sorter_ctrl_mm.sv
// Bit sorter control: groups coded-bit beats into QPSK..256-QAM symbols across NBANK banks.
// Define SORTER_PAD_EN to zero-pad and publish a partial final symbol; otherwise it is discarded.
module sorter_ctrl_mm #(
  parameter int IN_W   = 2,
  parameter int NBANK  = 2,
  parameter int SLOT_W = 3,
  localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        M,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NBANK-1:0]  load,
  output logic [SLOT_W-1:0] slot,
  output logic              pad,
  output logic              sym_valid,
  output logic [BW-1:0]     sym_bank,
  input  logic              sym_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [1:0]        mlat;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] last_slot;
  logic [NBANK-1:0]  full;
  logic [NBANK-1:0]  full_next;
  logic [BW-1:0]     wr_ptr;
  logic [BW-1:0]     rd_ptr;
  logic              run;
  logic              drain;
  logic              wr_free;
  logic              accept;
  logic              pad_wr;
  logic              step;
  logic              close;
  logic              consume;

  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    if (p == BW'(NBANK - 1)) return '0;
    return p + BW'(1);
  endfunction

  // Beats per symbol minus one: k/IN_W - 1 with k = 2*(mlat+1).
  assign last_slot = SLOT_W'(((2 * (int'(mlat) + 1)) / IN_W) - 1);

  assign run     = (state == RUN);
  assign drain   = (state == DRAIN);
  assign wr_free = !full[wr_ptr];
  assign accept  = run && in_valid && wr_free;
`ifdef SORTER_PAD_EN
  assign pad_wr  = drain && (slot_cnt != '0) && wr_free;
`else
  assign pad_wr  = 1'b0;
`endif
  assign step    = accept || pad_wr;
  assign close   = step && (slot_cnt == last_slot);
  assign consume = full[rd_ptr] && sym_ready;

  assign in_ready  = run && wr_free;
  assign pad       = pad_wr;
  assign slot      = slot_cnt;
  assign sym_valid = full[rd_ptr];
  assign sym_bank  = rd_ptr;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_load
      assign load[gi] = step && (wr_ptr == BW'(gi));
    end
  endgenerate

  // Consume and close never hit the same bank: one needs it full, the other free.
  always_comb begin
    full_next = full;
    if (consume) full_next[rd_ptr] = 1'b0;
    if (close)   full_next[wr_ptr] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (!start) state_next = DRAIN;
      DRAIN:   if ((slot_cnt == '0) && (full == '0)) state_next = DONE;
      default: state_next = start ? RUN : IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mlat     <= 2'd0;
      slot_cnt <= '0;
      full     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_next;
      if (((state == IDLE) || (state == DONE)) && start) mlat <= M;
      if ((state == IDLE) && start) begin
        slot_cnt <= '0;
        full     <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (step) slot_cnt <= close ? '0 : slot_cnt + SLOT_W'(1);
`ifndef SORTER_PAD_EN
        // Leaving RUN drops any partial symbol; a completing beat has already closed its bank.
        if (run && !start) slot_cnt <= '0;
`endif
        if (close)   wr_ptr <= ptr_inc(wr_ptr);
        if (consume) rd_ptr <= ptr_inc(rd_ptr);
        full <= full_next;
      end
    end
  end

endmodule

// File: tb/tb_sorter_ctrl_mm.sv
// Scoreboard bench for sorter_ctrl_mm: a symbol-level model predicts every load strobe and
// every published bank; a monitor compares them as the DUT presents them.
module tb_sorter_ctrl_mm;
  localparam int IN_W   = 2;
  localparam int NBANK  = 2;
  localparam int SLOT_W = 3;
  localparam int BW     = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        M = 2'd0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              sym_ready = 1'b0;
  logic              in_ready;
  logic [NBANK-1:0]  load;
  logic [SLOT_W-1:0] slot;
  logic              pad;
  logic              sym_valid;
  logic [BW-1:0]     sym_bank;
  logic              busy;
  logic              done;

  sorter_ctrl_mm #(.IN_W(IN_W), .NBANK(NBANK), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst(rst), .M(M), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .slot(slot), .pad(pad), .sym_valid(sym_valid), .sym_bank(sym_bank),
    .sym_ready(sym_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_load[$];
  int exp_pub[$];
  int m_beats = 1;
  int m_slot = 0;
  int m_bank = 0;
  bit rand_rdy = 1'b0;
  bit m_scramble = 1'b0;
  bit mon_en = 1'b0;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic int enc(input int b, input int s, input int p);
    return b * 256 + s * 2 + p;
  endfunction

  // Model: beat i of a frame lands at slot i%B of bank (base + i/B) % NBANK.
  task automatic push_beat(input int p);
    exp_load.push_back(enc(m_bank, m_slot, p));
    m_slot++;
    if (m_slot == m_beats) begin
      exp_pub.push_back(m_bank);
      m_slot = 0;
      m_bank = (m_bank + 1) % NBANK;
    end
  endtask

  task automatic set_mode(input int m, input bit keep_bank);
    M = 2'(m);
    m_beats = 2 * (m + 1) / IN_W;
    m_slot = 0;
    if (!keep_bank) m_bank = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) sym_ready = 1'($urandom_range(0, 1));
    if (m_scramble) M = 2'($urandom_range(0, 3));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_load"}, int'(load), 0);
    chk({tag, "_slot"}, int'(slot), 0);
    chk({tag, "_pad"}, int'(pad), 0);
    chk({tag, "_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_sym_bank"}, int'(sym_bank), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic start_from_idle(input int m);
    set_mode(m, 1'b0);
    start = 1'b1;
    @(negedge clk);
    chk("busy_in_idle", int'(busy), 0);
    tick();
    m_scramble = 1'b1;
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    tick();
  endtask

  task automatic start_from_done(input int m);
    set_mode(m, 1'b1);
    start = 1'b1;
    tick();
    m_scramble = 1'b1;
  endtask

  task automatic send_beats(input int n);
    int cnt = 0;
    int guard = 0;
    while (cnt < n && guard < 1000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        push_beat(0);
        cnt++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (cnt < n) chk("beats_accepted", cnt, n);
  endtask

  // Ends at the falling edge of the done cycle.
  task automatic end_frame();
    bit seen = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
`ifdef SORTER_PAD_EN
    while (m_slot != 0) push_beat(1);
`else
    m_slot = 0;
`endif
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) chk("done_seen", int'(done), 1);
    chk("loads_outstanding", exp_load.size(), 0);
    chk("pubs_outstanding", exp_pub.size(), 0);
    m_scramble = 1'b0;
  endtask

  initial begin : monitor
    bit prev_done = 1'b0;
    int b;
    int act;
    forever begin
      @(negedge clk);
      #1;
      if (rst && mon_en) begin
        if (load != '0) begin
          b = -1;
          for (int i = 0; i < NBANK; i++) if (load[i]) b = (b == -1) ? i : 99;
          act = enc(b, int'(slot), int'(pad));
          if (exp_load.size() == 0) chk("unexpected_load", act, -1);
          else chk("load", act, exp_load.pop_front());
        end
        if (sym_valid && sym_ready) begin
          if (exp_pub.size() == 0) chk("unexpected_publish", int'(sym_bank), -1);
          else chk("sym_bank", int'(sym_bank), exp_pub.pop_front());
        end
        if (prev_done) chk("done_one_cycle", int'(done), 0);
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // QPSK-pair scenario: 16-QAM, 8 beats, mapper always ready.
    rand_rdy = 1'b0;
    sym_ready = 1'b1;
    start_from_idle(1);
    send_beats(8);
    end_frame();
    tick();

    // 64-QAM with a partial final symbol.
    rand_rdy = 1'b1;
    start_from_idle(2);
    send_beats(4);
    end_frame();
    tick();

    // Backpressure: both banks full, one consume frees a bank for the next cycle.
    rand_rdy = 1'b0;
    sym_ready = 1'b0;
    start_from_idle(3);
    send_beats(8);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("in_ready_while_full", int'(in_ready), 0);
      chk("sym_valid_while_full", int'(sym_valid), 1);
      tick();
    end
    sym_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_before_consume", int'(in_ready), 0);
    tick();
    sym_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_consume", int'(in_ready), 1);
    tick();
    rand_rdy = 1'b1;
    end_frame();

    // Asynchronous reset with both banks full, then a fresh frame from bank 0.
    rand_rdy = 1'b0;
    sym_ready = 1'b0;
    start_from_done(3);
    send_beats(8);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mon_en = 1'b0;
    exp_load.delete();
    exp_pub.delete();
    m_scramble = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();
    rand_rdy = 1'b1;
    start_from_idle(0);
    send_beats(3);
    end_frame();

    // Random frames, chained through DONE or restarted from IDLE.
    for (int f = 0; f < 25; f++) begin
      int m;
      int n;
      m = $urandom_range(0, 3);
      n = $urandom_range(1, 10);
      if ($urandom_range(0, 1) == 1) begin
        start_from_done(m);
      end else begin
        tick();
        start_from_idle(m);
      end
      send_beats(n);
      end_frame();
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sorter_ctrl_mm.md
# sorter_ctrl_mm

Multi-mode, multi-bank control unit for the bit sorter in the V2V transmit chain. It groups incoming coded-bit beats into QPSK, 16-QAM, 64-QAM or 256-QAM symbols. Symbols are written round-robin into NBANK datapath banks. Completed banks are published to the mapper through a valid/ready handshake. A partial final symbol is zero-padded.

## Interface
Parameters:
- IN_W, 2, bits per input beat; legal values 1 or 2.
- NBANK, 2, number of symbol banks; 1..8.
- SLOT_W, 3, width of the slot index; must hold 8/IN_W-1.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- M  in  2  modulation: 0 QPSK, 1 16-QAM, 2 64-QAM, 3 256-QAM. Sampled only when a frame is entered.
- start  in  1  frame enable. High starts and sustains a frame; low ends it.
- in_valid  in  1  input beat present.
- in_ready  out  1  beat accepted on the current edge when in_valid & in_ready.
- load  out  NBANK  one-hot write strobe to the datapath bank.
- slot  out  SLOT_W  slot within the bank to write.
- pad  out  1  datapath writes zeros instead of input bits.
- sym_valid  out  1  a completed bank is available.
- sym_bank  out  $clog2(NBANK) (min 1)  bank index presented to the mapper.
- sym_ready  in  1  mapper consumes the bank.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle end-of-frame pulse.

## Operation
- Bits per symbol: k = 2·(Mlat+1), i.e. 2/4/6/8. Beats per symbol: B = k/IN_W.
- State machine:
  - IDLE → RUN when start=1. M is latched into Mlat; counters are cleared.
  - RUN → DRAIN when start=0.
  - DRAIN → DONE when slot=0 and no bank is full.
  - DONE → RUN when start=1 (M is re-latched); otherwise DONE → IDLE.
- Registers: wr_ptr, rd_ptr (mod NBANK), slot counter, and full[NBANK].
- RUN:
  - in_ready = !full[wr_ptr].
  - On acceptance, load = onehot(wr_ptr) and pad=0 in the same cycle (combinational from in_valid & in_ready).
  - Then slot increments. At slot = B-1: slot←0, full[wr_ptr]←1, wr_ptr advances.
- DRAIN with slot≠0 (padding):
  - Each cycle with !full[wr_ptr], the block asserts load and pad=1. in_ready=0.
  - Slot advances and closes the bank exactly as in RUN.
- Output side:
  - sym_valid = full[rd_ptr] and sym_bank = rd_ptr, both straight from registers.
  - When sym_valid & sym_ready: full[rd_ptr]←0 and rd_ptr advances.
- Simultaneous events:
  - A bank close and a consume on different banks in the same cycle both take effect.
  - A bank freed on edge n is writable from cycle n+1.
  - For NBANK=1, a write and a read never target a free/full bank at the same time; no special case is needed.
- Mode change (M) during RUN/DRAIN is ignored.
- in_valid outside RUN is ignored: in_ready=0, no load.
- Wrap-around: the pointers wrap NBANK-1→0. The slot counter never exceeds B-1.

## Timing
- Reset values: in_ready=0, load=0, slot=0, pad=0, sym_valid=0, sym_bank=0, busy=0, done=0. Internally: state=IDLE, all full=0, pointers=0.
- Reset mid-frame clears everything immediately. Partial and published banks are dropped.
- Latency: sym_valid rises on the cycle after the edge that accepted the last beat.
- Throughput: one beat per cycle while a free bank exists.
- start=1 for one cycle in IDLE → busy on the next cycle.
- done is high for exactly one cycle, in DONE. busy is high in RUN, DRAIN and DONE.

## Configuration
- SORTER_PAD_EN defined: the partial final symbol is zero-padded as above and published.
- SORTER_PAD_EN undefined: on entry to DRAIN a partial symbol is discarded. The slot is cleared, no pad loads are issued, and the bank stays free. pad is tied to 0. DRAIN then waits only for full=0.

## Test plan
- IN_W=2, NBANK=2, M=1, 8 beats, sym_ready=1: load alternates bank 0 ×2, then bank 1 ×2. sym_valid pulses for 1 cycle after each pair; 4 symbols total; done 1 cycle after the last consume.
- M=3, sym_ready=0: after 8 beats both banks are full. in_ready=0 and stays 0 until one sym_ready, then in_ready=1 on the next cycle.
- M=2, start drops after 4 beats (SORTER_PAD_EN): 2 pad loads at slots 1,2 with pad=1. Bank 1 is published; done follows.
- Same as the previous scenario without SORTER_PAD_EN: only bank 0 is published, no pad strobes, done follows.
- M changes 0→3 mid-RUN: symbols stay at 1 beat each until DONE. The next frame uses 4 beats.
- rst low mid-frame with 2 banks full: all outputs go to reset values asynchronously. After release, a new start begins at bank 0, slot 0.
